// File: rtl/ascii_num_sep_top_spec.sv
// ascii_num_sep_top_spec: parses signed decimal ASCII tokens from a byte stream into a number RAM.
// Latency: a completed number is counted one cycle after its ending byte; rd_data is a 1-cycle synchronous read.
// Backpressure: pkt_payload_ready drops only for the single DONE cycle after a last byte is accepted.
// Ports: clk/rst (sync active-high), buf_clear (sync clear of parser and count state),
//        pkt_payload_* byte stream (valid/ready/last), rd_addr/rd_data read port,
//        processing/done/invalid status, num_count numbers stored.
module ascii_num_sep_top_spec #(
    parameter int MAX_PAYLOAD = 1200,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 2048,
    parameter int ADDR_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_clear,
    input  logic [7:0]            pkt_payload_data,
    input  logic                  pkt_payload_valid,
    input  logic                  pkt_payload_last,
    output logic                  pkt_payload_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  processing,
    output logic                  done,
    output logic                  invalid,
    output logic [ADDR_WIDTH-1:0] num_count
);

    // Accumulator needs headroom for value*10+9 before the overflow compare.
    localparam int ACC_W = DATA_WIDTH + 4;
    // One extra count bit so a completely full buffer (DEPTH == 2**ADDR_WIDTH) is distinguishable.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int BC_W  = $clog2(MAX_PAYLOAD + 1);

    localparam logic [ACC_W-1:0] POS_LIM = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_LIM = POS_LIM + ACC_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [BC_W-1:0]  MAX_C   = BC_W'(MAX_PAYLOAD);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t            state_q;
    logic              ready_q;
    logic              done_q;
    logic              proc_q;
    logic              invalid_q;
    logic [CNT_W-1:0]  count_q;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;

    // Token state: started, negative, has at least one digit, skipping after an error.
    logic              tok_q,  tok_d;
    logic              neg_q,  neg_d;
    logic              dig_q,  dig_d;
    logic              skip_q, skip_d;
    logic [ACC_W-1:0]  acc_q,  acc_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic              accept;
    logic              full;
    logic              is_sep, is_digit, is_minus;
    logic              over;
    logic              sep_end;
    logic              err;
    logic              wr_en;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [BC_W-1:0]   cnt_base;
    logic [ACC_W-1:0]  acc_mul;
    logic [ACC_W-1:0]  lim;

    assign accept   = pkt_payload_valid && ready_q && !buf_clear && !rst;
    assign full     = (count_q >= DEPTH_C);
    assign is_sep   = (pkt_payload_data == 8'h20) || (pkt_payload_data == 8'h2C) ||
                      (pkt_payload_data == 8'h09) || (pkt_payload_data == 8'h0D) ||
                      (pkt_payload_data == 8'h0A);
    assign is_digit = (pkt_payload_data >= 8'h30) && (pkt_payload_data <= 8'h39);
    assign is_minus = (pkt_payload_data == 8'h2D);

    always_comb begin
        tok_d      = tok_q;
        neg_d      = neg_q;
        dig_d      = dig_q;
        skip_d     = skip_q;
        acc_d      = acc_q;
        byte_cnt_d = byte_cnt_q;
        sep_end    = 1'b0;
        err        = 1'b0;
        wr_en      = 1'b0;
        wr_dat     = '0;
        // A byte accepted in IDLE starts a fresh packet byte count.
        cnt_base   = (state_q == S_IDLE) ? '0 : byte_cnt_q;
        over       = (cnt_base >= MAX_C);
        // ASCII digits carry their value in the low nibble.
        acc_mul    = (acc_q << 3) + (acc_q << 1) + ACC_W'(pkt_payload_data[3:0]);
        lim        = neg_q ? NEG_LIM : POS_LIM;

        if (accept) begin
            if (over) begin
                // Payload bytes past the limit are dropped, but last still ends the packet.
                byte_cnt_d = cnt_base;
                err        = 1'b1;
            end else begin
                byte_cnt_d = cnt_base + BC_W'(1);
                if (skip_q) begin
                    if (is_sep) skip_d = 1'b0;
                end else if (is_sep) begin
                    sep_end = 1'b1;
                end else if (is_digit) begin
                    if (acc_mul > lim) begin
                        err    = 1'b1;
                        skip_d = 1'b1;
                        tok_d  = 1'b0;
                        neg_d  = 1'b0;
                        dig_d  = 1'b0;
                        acc_d  = '0;
                    end else begin
                        tok_d = 1'b1;
                        dig_d = 1'b1;
                        acc_d = acc_mul;
                    end
                end else if (is_minus && !tok_q) begin
                    tok_d = 1'b1;
                    neg_d = 1'b1;
                end else begin
                    err    = 1'b1;
                    skip_d = 1'b1;
                    tok_d  = 1'b0;
                    neg_d  = 1'b0;
                    dig_d  = 1'b0;
                    acc_d  = '0;
                end
            end

            // Completion sees the post-byte token, so a digit carrying last is included.
            if ((sep_end || pkt_payload_last) && tok_d) begin
                wr_dat = neg_d ? ('0 - acc_d[DATA_WIDTH-1:0]) : acc_d[DATA_WIDTH-1:0];
                if (!dig_d || full) begin
                    err = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
                tok_d = 1'b0;
                neg_d = 1'b0;
                dig_d = 1'b0;
                acc_d = '0;
            end

            if (pkt_payload_last) skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || buf_clear) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            proc_q     <= 1'b0;
            invalid_q  <= 1'b0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            tok_q      <= 1'b0;
            neg_q      <= 1'b0;
            dig_q      <= 1'b0;
            skip_q     <= 1'b0;
            acc_q      <= '0;
        end else begin
            done_q     <= 1'b0;
            byte_cnt_q <= byte_cnt_d;
            tok_q      <= tok_d;
            neg_q      <= neg_d;
            dig_q      <= dig_d;
            skip_q     <= skip_d;
            acc_q      <= acc_d;

            if (wr_en) count_q <= count_q + CNT_W'(1);

            // The first byte of a packet restarts the error flag.
            if (accept) invalid_q <= ((state_q == S_IDLE) ? 1'b0 : invalid_q) | err;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (pkt_payload_last) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RECV;
                            proc_q  <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (accept && pkt_payload_last) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        proc_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    proc_q  <= 1'b0;
                end
            endcase
        end
    end

    // Number RAM: not reset, written at the current count, read synchronously.
    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[ADDR_WIDTH-1:0]] <= wr_dat;
        rd_data_q <= mem[rd_addr];
    end

    assign pkt_payload_ready = ready_q;
    assign processing        = proc_q;
    assign done              = done_q;
    assign invalid           = invalid_q;
    assign rd_data           = rd_data_q;
    assign num_count         = count_q[ADDR_WIDTH] ? {ADDR_WIDTH{1'b1}} : count_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_ascii_num_sep_top_spec.sv
// tb_ascii_num_sep_top_spec: directed bench for the ASCII number separator.
// Small MAX_PAYLOAD and DEPTH so payload-limit and buffer-full cases run in a few hundred cycles.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same offset.
module tb_ascii_num_sep_top_spec;

    localparam int MAXP = 16;
    localparam int DW   = 32;
    localparam int DEP  = 16;
    localparam int AW   = 5;

    logic          clk;
    logic          rst;
    logic          buf_clear;
    logic [7:0]    pkt_payload_data;
    logic          pkt_payload_valid;
    logic          pkt_payload_last;
    logic          pkt_payload_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          processing;
    logic          done;
    logic          invalid;
    logic [AW-1:0] num_count;

    int compared   = 0;
    int mismatched = 0;

    ascii_num_sep_top_spec #(
        .MAX_PAYLOAD (MAXP),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEP),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .buf_clear         (buf_clear),
        .pkt_payload_data  (pkt_payload_data),
        .pkt_payload_valid (pkt_payload_valid),
        .pkt_payload_last  (pkt_payload_last),
        .pkt_payload_ready (pkt_payload_ready),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .processing        (processing),
        .done              (done),
        .invalid           (invalid),
        .num_count         (num_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int n;
        n = 0;
        pkt_payload_data  = b;
        pkt_payload_last  = l;
        pkt_payload_valid = 1'b1;
        while (!pkt_payload_ready && n < 8) begin
            tick();
            n++;
        end
        if (!pkt_payload_ready) begin
            compared++;
            mismatched++;
            $display("FAIL ready_wait: observed ready=0 required ready=1");
        end
        tick();
        pkt_payload_valid = 1'b0;
        pkt_payload_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_end);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last_end && (i == s.len() - 1));
        end
    endtask

    task automatic clear_buf();
        buf_clear = 1'b1;
        tick();
        buf_clear = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic [31:0] exp);
        rd_addr = AW'(idx);
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst               = 1'b1;
        buf_clear         = 1'b0;
        pkt_payload_data  = 8'h00;
        pkt_payload_valid = 1'b0;
        pkt_payload_last  = 1'b0;
        rd_addr           = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_count", 32'(num_count), 0);
        chk("rst_invalid", 32'(invalid), 0);
        chk("rst_processing", 32'(processing), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(pkt_payload_ready), 1);
        rst = 1'b0;
        tick();

        // Basic mixed-sign packet
        send_str("12 -3 45\n", 1'b1);
        chk("p1_done", 32'(done), 1);
        chk("p1_ready_low", 32'(pkt_payload_ready), 0);
        chk("p1_count", 32'(num_count), 3);
        chk("p1_proc_low", 32'(processing), 0);
        tick();
        chk("p1_done_once", 32'(done), 0);
        chk("p1_ready_back", 32'(pkt_payload_ready), 1);
        chk("p1_invalid", 32'(invalid), 0);
        rd_chk("p1_ram0", 0, 32'd12);
        rd_addr = AW'(1);
        chk("p1_rd_not_before", rd_data, 32'd12);
        tick();
        chk("p1_ram1", rd_data, 32'hFFFF_FFFD);
        rd_chk("p1_ram2", 2, 32'd45);

        // Signed range limits
        clear_buf();
        chk("clr_count", 32'(num_count), 0);
        send_str("-2147483648\n", 1'b1);
        tick();
        chk("min_count", 32'(num_count), 1);
        chk("min_invalid", 32'(invalid), 0);
        rd_chk("min_ram0", 0, 32'h8000_0000);
        send_str("2147483648\n", 1'b1);
        tick();
        chk("ovf_invalid", 32'(invalid), 1);
        chk("ovf_count", 32'(num_count), 1);

        // Bad character discards only its token
        clear_buf();
        send_str("1a 5\n", 1'b1);
        tick();
        chk("bad_invalid", 32'(invalid), 1);
        chk("bad_count", 32'(num_count), 1);
        rd_chk("bad_ram0", 0, 32'd5);

        // Last on a digit, then append across packets; new packet clears invalid
        clear_buf();
        send_str("7,8", 1'b1);
        chk("lastdig_done", 32'(done), 1);
        chk("lastdig_count", 32'(num_count), 2);
        tick();
        send_str("9\n", 1'b1);
        tick();
        chk("app_count", 32'(num_count), 3);
        chk("app_invalid", 32'(invalid), 0);
        rd_chk("app_ram0", 0, 32'd7);
        rd_chk("app_ram1", 1, 32'd8);
        rd_chk("app_ram2", 2, 32'd9);

        // buf_clear mid-packet, colliding with a valid byte
        clear_buf();
        send_str("5 6", 1'b0);
        chk("mid_proc", 32'(processing), 1);
        chk("mid_count", 32'(num_count), 1);
        pkt_payload_data  = 8'h37;
        pkt_payload_valid = 1'b1;
        buf_clear         = 1'b1;
        tick();
        pkt_payload_valid = 1'b0;
        buf_clear         = 1'b0;
        chk("clr_mid_count", 32'(num_count), 0);
        chk("clr_mid_proc", 32'(processing), 0);
        chk("clr_mid_invalid", 32'(invalid), 0);
        chk("clr_mid_done", 32'(done), 0);
        send_str("4\n", 1'b1);
        tick();
        chk("after_clr_count", 32'(num_count), 1);
        rd_chk("after_clr_ram0", 0, 32'd4);

        // Lone minus, then a run of separators
        send_str("-\n", 1'b1);
        tick();
        chk("lone_minus_invalid", 32'(invalid), 1);
        chk("lone_minus_count", 32'(num_count), 1);
        send_str("\t, 3", 1'b0);
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0A, 1'b1);
        tick();
        chk("seps_count", 32'(num_count), 2);
        chk("seps_invalid", 32'(invalid), 0);
        rd_chk("seps_ram1", 1, 32'd3);

        // Payload limit: bytes 17 and 18 are dropped, last still ends the packet
        clear_buf();
        send_str("1 2 3 4 5 6 7 8 9\n", 1'b1);
        chk("maxp_done", 32'(done), 1);
        tick();
        chk("maxp_count", 32'(num_count), 8);
        chk("maxp_invalid", 32'(invalid), 1);
        rd_chk("maxp_ram7", 7, 32'd8);
        send_str("3\n", 1'b1);
        tick();
        chk("maxp_next_count", 32'(num_count), 9);
        chk("maxp_next_invalid", 32'(invalid), 0);
        rd_chk("maxp_next_ram8", 8, 32'd3);

        // Buffer full: count saturates at DEPTH
        clear_buf();
        send_str("1 2 3 4 5 6 7 8\n", 1'b1);
        tick();
        send_str("1 2 3 4 5 6 7 8\n", 1'b1);
        tick();
        chk("full_count", 32'(num_count), 16);
        chk("full_invalid", 32'(invalid), 0);
        send_str("9\n", 1'b1);
        tick();
        chk("sat_count", 32'(num_count), 16);
        chk("sat_invalid", 32'(invalid), 1);
        rd_chk("sat_ram15", 15, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
